// File: rtl/set_reset_debouncer.sv
// set_reset_debouncer: two-flop synchronizer plus counting FSM giving a clean level and set/reset edge pulses
module set_reset_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic Q,
  output logic Q_L,
  output logic S,
  output logic R
);
  typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);
  state_t r_state, w_state_n;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt_n;
  logic r_s1, r_s2, r_q, r_ql, r_s, r_r;
  logic w_q_n, w_s_n, w_r_n;
  assign Q = r_q;
  assign Q_L = r_ql;
  assign S = r_s;
  assign R = r_r;
  // bring the asynchronous input into the clock domain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end
  // state, counter and all outputs are registered here so nothing combinational reaches the ports
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE_LOW;
      r_cnt <= '0;
      r_q <= 1'b0;
      r_ql <= 1'b1;
      r_s <= 1'b0;
      r_r <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt <= w_cnt_n;
      r_q <= w_q_n;
      r_ql <= ~w_q_n;
      r_s <= w_s_n;
      r_r <= w_r_n;
    end
  end
  // a new level needs DEBOUNCE_CYCLES consecutive synchronized samples; any revert drops back to idle
  always_comb begin
    w_state_n = r_state;
    w_cnt_n = r_cnt;
    w_q_n = r_q;
    w_s_n = 1'b0;
    w_r_n = 1'b0;
    case (r_state)
      IDLE_LOW: if (r_s2) begin
        w_state_n = WAIT_HIGH;
        w_cnt_n = ONE;
      end
      WAIT_HIGH: if (!r_s2) begin
        w_state_n = IDLE_LOW;
        w_cnt_n = '0;
      end else if (r_cnt == LAST) begin
        w_state_n = IDLE_HIGH;
        w_cnt_n = '0;
        w_q_n = 1'b1;
        w_s_n = 1'b1;
      end else w_cnt_n = r_cnt + ONE;
      IDLE_HIGH: if (!r_s2) begin
        w_state_n = WAIT_LOW;
        w_cnt_n = ONE;
      end
      WAIT_LOW: if (r_s2) begin
        w_state_n = IDLE_HIGH;
        w_cnt_n = '0;
      end else if (r_cnt == LAST) begin
        w_state_n = IDLE_LOW;
        w_cnt_n = '0;
        w_q_n = 1'b0;
        w_r_n = 1'b1;
      end else w_cnt_n = r_cnt + ONE;
      default: begin
        w_state_n = IDLE_LOW;
        w_cnt_n = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_set_reset_debouncer.sv
// tb_set_reset_debouncer: scenario tasks plus randomized run against a run-length reference model
module tb_set_reset_debouncer;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1, btn = 1'b0;
  logic Q, Q_L, S, R;
  int total = 0, passed = 0;
  logic m_p1 = 1'b0, m_p2 = 1'b0, m_q = 1'b0, m_s = 1'b0, m_r = 1'b0;
  int m_run = 0;

  set_reset_debouncer #(.DEBOUNCE_CYCLES(N), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .btn(btn), .Q(Q), .Q_L(Q_L), .S(S), .R(R));

  always #5 clk = ~clk;

  // drive one cycle, advance the model by the same edge, settle 1 time unit after the edge
  task automatic tick(input logic b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    if (r) begin
      {m_p1, m_p2, m_q, m_s, m_r} = '0;
      m_run = 0;
    end else begin
      m_s = 1'b0;
      m_r = 1'b0;
      if (m_p2 !== m_q) begin
        m_run++;
        if (m_run == N) begin
          m_q = m_p2;
          m_s = m_q;
          m_r = !m_q;
          m_run = 0;
        end
      end else m_run = 0;
      m_p2 = m_p1;
      m_p1 = b;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      tick(k[0], 1'b1);
      total++;
      if ({Q, Q_L, S, R} !== 4'b0100) $display("FAIL reset k=%0d got %b exp 0100", k, {Q, Q_L, S, R});
      else passed++;
    end
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
  endtask

  task automatic test_clean_press();
    int s_at = -1, s_cnt = 0, r_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      tick(1'b1, 1'b0);
      if (S) begin s_at = k; s_cnt++; end
      if (R) r_cnt++;
      total++;
      if ({Q, Q_L, S, R} !== {m_q, !m_q, m_s, m_r}) $display("FAIL clean_press k=%0d got %b exp %b", k, {Q, Q_L, S, R}, {m_q, !m_q, m_s, m_r});
      else passed++;
    end
    total++;
    if (s_at !== 5 || s_cnt !== 1 || r_cnt !== 0 || Q_L !== 1'b0) $display("FAIL clean_press_timing s_at=%0d s_cnt=%0d r_cnt=%0d q_l=%b exp 5 1 0 0", s_at, s_cnt, r_cnt, Q_L);
    else passed++;
  endtask

  task automatic test_release();
    int r_at = -1, r_cnt = 0, s_cnt = 0;
    for (int k = 0; k < 9; k++) begin
      tick(1'b0, 1'b0);
      if (R) begin r_at = k; r_cnt++; end
      if (S) s_cnt++;
      total++;
      if ({Q, Q_L, S, R} !== {m_q, !m_q, m_s, m_r}) $display("FAIL release k=%0d got %b exp %b", k, {Q, Q_L, S, R}, {m_q, !m_q, m_s, m_r});
      else passed++;
    end
    total++;
    if (r_at !== 5 || r_cnt !== 1 || s_cnt !== 0 || {Q, Q_L} !== 2'b01) $display("FAIL release_timing r_at=%0d r_cnt=%0d s_cnt=%0d q=%b exp 5 1 0 0", r_at, r_cnt, s_cnt, Q);
    else passed++;
  endtask

  task automatic test_bouncy_press();
    logic [4:0] pat = 5'b01101;
    int s_at = -1, s_cnt = 0;
    for (int k = 0; k < 14; k++) begin
      tick(k < 5 ? pat[k] : 1'b1, 1'b0);
      if (S) begin s_at = k; s_cnt++; end
      total++;
      if ({Q, Q_L, S, R} !== {m_q, !m_q, m_s, m_r}) $display("FAIL bouncy k=%0d got %b exp %b", k, {Q, Q_L, S, R}, {m_q, !m_q, m_s, m_r});
      else passed++;
    end
    total++;
    if (s_at !== 10 || s_cnt !== 1) $display("FAIL bouncy_timing s_at=%0d s_cnt=%0d exp 10 1", s_at, s_cnt);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    for (int k = 0; k < 4; k++) tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    total++;
    if ({Q, Q_L, S, R} !== 4'b0100) $display("FAIL reset_mid got %b exp 0100", {Q, Q_L, S, R});
    else passed++;
    for (int k = 0; k < 10; k++) begin
      tick(1'b0, 1'b0);
      pulses += int'(S) + int'(R);
    end
    total++;
    if (pulses !== 0 || Q !== 1'b0) $display("FAIL reset_mid_quiet pulses=%0d q=%b exp 0 0", pulses, Q);
    else passed++;
  endtask

  task automatic test_late_glitch();
    int s_at = -1, s_cnt = 0;
    for (int k = 0; k < 13; k++) begin
      tick(k == 3 ? 1'b0 : 1'b1, 1'b0);
      if (S) begin s_at = k; s_cnt++; end
      total++;
      if ({Q, Q_L, S, R} !== {m_q, !m_q, m_s, m_r}) $display("FAIL late_glitch k=%0d got %b exp %b", k, {Q, Q_L, S, R}, {m_q, !m_q, m_s, m_r});
      else passed++;
    end
    total++;
    if (s_at !== 9 || s_cnt !== 1) $display("FAIL late_glitch_timing s_at=%0d s_cnt=%0d exp 9 1", s_at, s_cnt);
    else passed++;
  endtask

  task automatic test_reset_accept();
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1);
    for (int k = 0; k < 5; k++) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    total++;
    if ({Q, Q_L, S, R} !== 4'b0100) $display("FAIL reset_accept got %b exp 0100", {Q, Q_L, S, R});
    else passed++;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 1'b0);
      total++;
      if ({Q, Q_L, S, R} !== {m_q, !m_q, m_s, m_r} || (k == 5 && S !== 1'b1)) $display("FAIL btn_high_at_reset k=%0d got %b exp %b", k, {Q, Q_L, S, R}, {m_q, !m_q, m_s, m_r});
      else passed++;
    end
  endtask

  task automatic test_random();
    int hold = 0;
    logic b = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (hold == 0) begin
        b = ~b;
        hold = $urandom_range(1, 8);
      end
      hold--;
      tick(b, $urandom_range(0, 59) == 0);
      total++;
      if ({Q, Q_L, S, R} !== {m_q, !m_q, m_s, m_r} || (S && R)) $display("FAIL random k=%0d got %b exp %b", k, {Q, Q_L, S, R}, {m_q, !m_q, m_s, m_r});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_release();
    test_bouncy_press();
    test_reset_mid();
    test_late_glitch();
    test_reset_accept();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
